// File: rtl/problem_pkg.sv
// Shared types and defaults for the press-toggle LED block.
package problem_pkg;

  // Four-state Moore FSM; bit 0 carries the LED value for the ON states.
  typedef enum logic [1:0] {
    OFF_RELEASED = 2'b00,
    ON_PRESSED   = 2'b01,
    ON_RELEASED  = 2'b11,
    OFF_PRESSED  = 2'b10
  } toggle_state_e;

  // Default number of synchronizer flops in front of the FSM.
  localparam int SYNC_STAGES_DEFAULT = 0;

  // LED is lit in both ON states.
  function automatic logic led_of(input toggle_state_e s);
    return (s == ON_PRESSED) || (s == ON_RELEASED);
  endfunction

endpackage

// File: rtl/problem_button_sync.sv
// Button synchronizer: STAGES flops cleared by reset, or a wire when STAGES is 0.
module button_sync #(
  parameter int STAGES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic btn_o
);

  generate
    if (STAGES == 0) begin : g_pass
      assign btn_o = btn_i;
    end else begin : g_flops
      logic [STAGES-1:0] sync_q;
      // Shift the raw button level through the chain; reset clears every flop.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q <= '0;
        end else if (STAGES == 1) begin
          sync_q <= btn_i;
        end else begin
          sync_q <= {sync_q[STAGES-2:0], btn_i};
        end
      end
      assign btn_o = sync_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/problem.sv
// Press-toggle LED: each rising edge of the (optionally synchronized) button
// inverts the LED once; holds and releases never change it.
//
// Handshake: none. button is a level input sampled on every rising clk edge;
// led is a registered level output valid from the first edge after reset.
module problem
  import problem_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic led
);

  logic          btn;
  toggle_state_e state_q, state_d;
  logic          led_q, led_d;

  button_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .btn_i (button),
    .btn_o (btn)
  );

  // Next-state logic; any unexpected encoding falls back to OFF_RELEASED.
  always_comb begin
    state_d = OFF_RELEASED;
    case (state_q)
      OFF_RELEASED: state_d = btn ? ON_PRESSED   : OFF_RELEASED;
      ON_PRESSED:   state_d = btn ? ON_PRESSED   : ON_RELEASED;
      ON_RELEASED:  state_d = btn ? OFF_PRESSED  : ON_RELEASED;
      OFF_PRESSED:  state_d = btn ? OFF_PRESSED  : OFF_RELEASED;
      default:      state_d = OFF_RELEASED;
    endcase
  end

  // Output decode of the next state, so led changes on the same edge as the state.
  always_comb begin
    led_d = led_of(state_d);
  end

  // State and LED registers; reset parks the FSM according to the current button
  // so a press held through reset is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= btn ? OFF_PRESSED : OFF_RELEASED;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_problem.sv
// Directed table of {reset, button, cycles, expected led} plus a random pulse train.
module tb_problem;

  logic clk = 1'b0;
  logic reset;
  logic button;
  logic led;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic  rst;
    logic  btn;
    int    cycles;
    logic  exp_led;
    string name;
  } vec_t;

  vec_t vecs[$];

  problem dut (
    .clk    (clk),
    .reset  (reset),
    .button (button),
    .led    (led)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard compare
  task automatic check(input string name, input int k, input logic exp);
    n_checks++;
    if (led === exp) n_pass++;
    else $display("FAIL %s cycle %0d: led=%b expected %b", name, k, led, exp);
  endtask

  // driver: apply inputs at negedge, let one rising edge pass, sample at next negedge
  task automatic step(input logic r, input logic b);
    reset  = r;
    button = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic b, input int n, input logic e, input string nm);
    vec_t v;
    v.rst = r; v.btn = b; v.cycles = n; v.exp_led = e; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    logic exp_q[$];
    logic exp_led;
    logic prev_btn;
    logic b;

    reset  = 1'b1;
    button = 1'b0;

    // reset and basic press sequence
    add(1, 0, 5,  0, "reset_hold");
    add(0, 0, 10, 0, "after_reset");
    add(0, 1, 1,  1, "press1_latency");
    add(0, 1, 10, 1, "press1_hold");
    add(0, 0, 12, 1, "release1");
    add(0, 1, 1,  0, "press2_latency");
    add(0, 1, 11, 0, "press2_hold");
    add(0, 0, 5,  0, "release2");
    add(0, 1, 1,  1, "press3_latency");
    add(0, 1, 9,  1, "press3_hold");
    // reset mid-press: held button must not toggle after reset
    add(1, 1, 1,  0, "reset_midpress");
    add(0, 1, 5,  0, "held_after_reset");
    add(0, 0, 3,  0, "release_after_reset");
    add(0, 1, 1,  1, "press_after_reset");
    add(0, 0, 2,  1, "release4");
    // one-cycle pulses
    add(0, 1, 1,  0, "pulse1");
    add(0, 0, 3,  0, "pulse1_after");
    add(0, 1, 1,  1, "pulse2");
    add(0, 0, 2,  1, "pulse2_after");
    // reset held with button pressed over several edges
    add(1, 1, 3,  0, "reset_btn_held");
    add(0, 1, 2,  0, "held_out_of_reset");
    add(0, 0, 2,  0, "release5");
    add(0, 1, 1,  1, "press6");
    add(0, 0, 2,  1, "release6");

    @(negedge clk);
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].cycles; k++) begin
        step(vecs[i].rst, vecs[i].btn);
        check(vecs[i].name, k, vecs[i].exp_led);
      end
    end

    // random pulse train: led parity follows the count of rising edges
    exp_led  = 1'b1;
    prev_btn = 1'b0;
    for (int k = 0; k < 300; k++) begin
      b = 1'($urandom_range(0, 1));
      if (b && !prev_btn) exp_led = ~exp_led;
      prev_btn = b;
      exp_q.push_back(exp_led);
      step(1'b0, b);
      check("pulse_train", k, exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/problem.md
PROBLEM -- requirements
Module: problem

Interface
REQ-001 Parameter SYNC_STAGES, default 0, is the number of input synchronizer flops on button; the legal range is 0..2.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port button, input, 1 bit: push-button level, 1 = pressed; changes away from rising clk edges.
REQ-005 Port led, output, 1 bit: toggle LED, 1 = lit; driven directly from a register.

Function
REQ-006 The block SHALL implement a press-toggle: each 0->1 transition of the sampled button inverts led exactly once.
REQ-007 The block SHALL use a Moore FSM with four states: OFF_RELEASED, ON_PRESSED, ON_RELEASED and OFF_PRESSED.
REQ-008 OFF_RELEASED with btn=1 SHALL go to ON_PRESSED; with btn=0 it SHALL stay.
REQ-009 ON_PRESSED with btn=0 SHALL go to ON_RELEASED; with btn=1 it SHALL stay.
REQ-010 ON_RELEASED with btn=1 SHALL go to OFF_PRESSED; with btn=0 it SHALL stay.
REQ-011 OFF_PRESSED with btn=0 SHALL go to OFF_RELEASED; with btn=1 it SHALL stay.
REQ-012 led SHALL be 1 in ON_PRESSED and ON_RELEASED, and 0 in OFF_RELEASED and OFF_PRESSED.
REQ-013 led SHALL be registered, so no combinational path exists from button to led.
REQ-014 btn is button delayed by SYNC_STAGES flops; with SYNC_STAGES=0, btn = button.
REQ-015 Latency from button rising to led change SHALL be SYNC_STAGES+1 rising clk edges.
REQ-016 With the default parameter, the latency SHALL be 1 edge and SHALL never exceed 2 edges.
REQ-017 Holding the button for any number of cycles SHALL produce exactly one toggle.
REQ-018 Releasing the button SHALL never change led.
REQ-019 A press held through reset deassertion SHALL NOT toggle led; the FSM waits in OFF_PRESSED until release.
REQ-020 A one-cycle pulse on btn SHALL count as a full press: toggle on the 0->1 edge, then the release on the following edge.
REQ-021 Unreachable state encodings SHALL recover to OFF_RELEASED on the next edge.

Reset
REQ-022 While reset=1 at a rising clk edge, the FSM SHALL load OFF_RELEASED if btn=0, or OFF_PRESSED if btn=1.
REQ-023 While reset=1, led SHALL be 0 at the first rising edge and remain 0 for the whole reset.
REQ-024 Reset SHALL clear all synchronizer flops to 0.
REQ-025 Reset SHALL take priority over every transition, including one that arrives mid-press.
REQ-026 There SHALL be no asynchronous reset paths.

Structure
REQ-027 The state enum typedef (four states, 2-bit encoding) and the SYNC_STAGES default SHALL live in shared package problem_pkg.
REQ-028 The synchronizer SHALL be a sub-module named button_sync, parameterized by stage count, with a pass-through when the count is 0.
REQ-029 The FSM SHALL be coded as separate next-state logic, a state register and output decode.

Verification
REQ-030 Reset: hold reset=1 for 5 cycles with button=0, then release -> led=0 for 10 cycles.
REQ-031 First press: button=1 after reset -> led=1 within 2 edges and stays 1 for 10 held cycles; button=0 -> led stays 1 for 12 cycles.
REQ-032 Second press: button=1 -> led=0 within 2 edges and stays 0 for 12 cycles; release -> led stays 0.
REQ-033 Third press: button=1 -> led=1 within 2 edges and stays 1 for 10 cycles.
REQ-034 Reset mid-press: button=1 and led=1, assert reset for 1 cycle -> led=0 and stays 0 until release; the next press gives led=1.
REQ-035 One-cycle pulse: button 0->1->0 over one cycle -> led toggles exactly once; random pulse trains -> led parity equals the count of rising edges.
